// File: rtl/config_tx_pkg.sv
`default_nettype none
//============================================================================
// Module : config_tx_pkg
// Shared state encoding and CRC-8 constants for the config-chain transmitter.
// Rev    : 1.0
//============================================================================
package config_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_GAP0  = 3'd2,
        ST_SET   = 3'd3,
        ST_GAP1  = 3'd4
    } tx_state_e;

    localparam logic [7:0] CRC8_POLY  = 8'h07;
    localparam logic [7:0] CRC8_INIT  = 8'h00;
    localparam int         GAP_CYCLES = 1;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        return {crc[6:0], 1'b0} ^ (((crc[7] ^ bit_in) == 1'b1) ? CRC8_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_tx_piso.sv
`default_nettype none
//============================================================================
// Module : config_tx_piso
// Loadable parallel-in/serial-out register, MSB first, with bit counter/done.
// Rev    : 1.0
//============================================================================
module config_tx_piso #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_msb,
    output logic             o_done
);

    localparam int                CNT_BITS = $clog2(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST   = CNT_BITS'(WIDTH - 1);

    logic [WIDTH-1:0]    sreg_q, sreg_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    // Zero fill means the register is empty once a word has fully shifted,
    // so the MSB doubles as a line that idles low.
    assign o_msb  = sreg_q[WIDTH-1];
    assign o_done = i_shift && (cnt_q == LAST);

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (i_load) begin
            sreg_d = i_din;
            cnt_d  = '0;
        end else if (i_shift) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/config_sram_stream_tx.sv
`default_nettype none
//============================================================================
// Module : config_sram_stream_tx
// Serializes (addr,data) words onto the config chain, then pulses config_set.
// Optional running CRC-8 on the shifted bits when CONFIG_TX_CRC_EN is defined.
// Rev    : 1.0
//============================================================================
module config_sram_stream_tx
    import config_tx_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 cclk,
    input  logic                 rst,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic [ADDR_BITS-1:0] word_addr,
    input  logic [DATA_BITS-1:0] word_data,
    output logic                 shift_enable,
    output logic                 shift_out,
    output logic                 config_set,
    output logic                 busy,
    output logic [7:0]           crc_out
);

    localparam int W = ADDR_BITS + DATA_BITS;

    tx_state_e state_q, state_d;
    logic      word_ready_q, word_ready_d;
    logic      shift_enable_q, shift_enable_d;
    logic      config_set_q, config_set_d;
    logic      busy_q, busy_d;
    logic      accept;
    logic      piso_done;

    config_tx_piso #(
        .WIDTH (W)
    ) u_piso (
        .clk     (cclk),
        .rst     (rst),
        .i_load  (accept),
        .i_shift (state_q == ST_SHIFT),
        .i_din   ({word_addr, word_data}),
        .o_msb   (shift_out),
        .o_done  (piso_done)
    );

    // Outputs are decoded from the next state so they are flop outputs
    // aligned with the state they describe.
    always_comb begin
        accept  = word_valid & word_ready_q;
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (piso_done) state_d = ST_GAP0;
            ST_GAP0:  state_d = ST_SET;
            ST_SET:   state_d = ST_GAP1;
            ST_GAP1:  state_d = accept ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        word_ready_d   = (state_d == ST_IDLE) || (state_d == ST_GAP1);
        shift_enable_d = (state_d == ST_SHIFT);
        config_set_d   = (state_d == ST_SET);
        busy_d         = (state_d != ST_IDLE);
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            word_ready_q   <= 1'b1;
            shift_enable_q <= 1'b0;
            config_set_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_ready_q   <= word_ready_d;
            shift_enable_q <= shift_enable_d;
            config_set_q   <= config_set_d;
            busy_q         <= busy_d;
        end
    end

    assign word_ready   = word_ready_q;
    assign shift_enable = shift_enable_q;
    assign config_set   = config_set_q;
    assign busy         = busy_q;

`ifdef CONFIG_TX_CRC_EN
    logic [7:0] crc_q, crc_d;

    // Runs across words; only reset clears it.
    always_comb begin
        crc_d = crc_q;
        if (shift_enable_q) begin
            crc_d = crc8_step(crc_q, shift_out);
        end
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;
`else
    assign crc_out = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_config_sram_stream_tx.sv
`default_nettype none
//============================================================================
// Module : tb_config_sram_stream_tx
// Randomized self-checking bench for config_sram_stream_tx (CONFIG_TX_CRC_EN aware).
// Rev    : 1.0
//============================================================================
module tb_config_sram_stream_tx;
    import config_tx_pkg::*;

    localparam int W      = 16;
    localparam int PERIOD = W + 2 * GAP_CYCLES + 1;

    logic       cclk = 1'b0;
    logic       rst = 1'b1;
    logic       word_valid = 1'b0;
    logic [7:0] word_addr = 8'h00;
    logic [7:0] word_data = 8'h00;
    logic       word_ready, shift_enable, shift_out, config_set, busy;
    logic [7:0] crc_out;

    always #5 cclk = ~cclk;

    config_sram_stream_tx #(
        .ADDR_BITS (8),
        .DATA_BITS (8)
    ) dut (
        .cclk         (cclk),
        .rst          (rst),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_addr    (word_addr),
        .word_data    (word_data),
        .shift_enable (shift_enable),
        .shift_out    (shift_out),
        .config_set   (config_set),
        .busy         (busy),
        .crc_out      (crc_out)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // CRC-8 as polynomial long division of message * x^8 by x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref(input logic [15:0] m);
        logic [23:0] r;
        r = {m, 8'h00};
        for (int i = 23; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    // Reference timeline: after an accept in cycle c, bits go out in c+1..c+W,
    // commit in c+W+2, ready again in c+W+3, idle afterwards.
    bit          m_active = 1'b0;
    int          m_k = 0;
    logic [15:0] m_cur = '0;
    logic [7:0]  m_crc = 8'h00;
    bit          rst_seen = 1'b1;
    int          cyc = 0;
    int          accepts = 0, commits = 0, dropped = 0;
    int          last_acc_cyc = 0, last_set_cyc = 0;
    logic [15:0] rx_word = '0;
    int          rx_n = 0;
    logic [15:0] last_commit = '0;
    logic [7:0]  mem [int];

    always @(negedge cclk) begin
        logic e_se, e_so, e_set, e_busy, e_rdy;
        cyc++;
        if (rst_seen) begin
            if (m_active && m_k <= W + 1) dropped++;
            m_active = 1'b0;
            m_k      = 0;
            m_crc    = 8'h00;
            rx_n     = 0;
        end else if (m_active) begin
            m_k++;
            if (m_k > W + 3) m_active = 1'b0;
        end
        e_se   = m_active && m_k >= 1 && m_k <= W;
        e_so   = e_se ? m_cur[W - m_k] : 1'b0;
        e_set  = m_active && m_k == W + 2;
        e_busy = m_active && m_k >= 1;
        e_rdy  = !m_active || m_k == W + 3;
        chk("shift_enable", shift_enable, e_se);
        chk("shift_out", shift_out, e_so);
        chk("config_set", config_set, e_set);
        chk("busy", busy, e_busy);
        chk("word_ready", word_ready, e_rdy);
`ifdef CONFIG_TX_CRC_EN
        chk("crc_out", crc_out, m_crc);
`else
        chk("crc_out", crc_out, 8'h00);
`endif
        if (e_se) m_crc = {m_crc[6:0], 1'b0} ^ (((m_crc[7] ^ e_so) == 1'b1) ? 8'h07 : 8'h00);

        // Chain receiver: rebuilds each word and writes the model SRAM on commit.
        if (shift_enable) begin
            rx_word = {rx_word[14:0], shift_out};
            rx_n++;
        end
        if (config_set) begin
            chk("commit_bits", rx_n, W);
            chk("commit_word", rx_word, m_cur);
            mem[int'(rx_word[15:8])] = rx_word[7:0];
            last_commit  = rx_word;
            last_set_cyc = cyc;
            commits++;
            rx_n = 0;
        end
        if (!rst && word_valid && e_rdy) begin
            m_active     = 1'b1;
            m_k          = 0;
            m_cur        = {word_addr, word_data};
            last_acc_cyc = cyc;
            accepts++;
        end
        rst_seen = rst;
    end

    // Presents a word and holds valid until it is taken; returns just after the accept edge.
    task automatic send(input logic [7:0] a, input logic [7:0] d);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        word_addr  = a;
        word_data  = d;
        word_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge cclk);
            if (word_ready) ok = 1'b1;
            n++;
        end
        @(posedge cclk);
        #1;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_commits(input int target);
        int n;
        n = 0;
        while (commits < target && n < 200) begin
            @(posedge cclk);
            #1;
            n++;
        end
        chk("commit_timeout", (commits >= target) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(posedge cclk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge cclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, prev;
        logic [7:0] exp_crc;

        repeat (3) @(posedge cclk);
        #1;
        rst = 1'b0;
        @(negedge cclk);
        chk("rst_word_ready", word_ready, 1'b1);
        chk("rst_shift_enable", shift_enable, 1'b0);
        chk("rst_shift_out", shift_out, 1'b0);
        chk("rst_config_set", config_set, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_crc", crc_out, 8'h00);
        @(posedge cclk);
        #1;

        // Single directed word.
        c0 = commits;
        send(8'hA5, 8'h3C);
        word_valid = 1'b0;
        wait_commits(c0 + 1);
        chk("single_word", last_commit, 16'hA53C);
        chk("single_latency", last_set_cyc - last_acc_cyc, W + 2);

        // Back-to-back stream with valid held high.
        c0 = commits;
        prev = 0;
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 8'(i));
            if (i > 0) chk("b2b_period", last_acc_cyc - prev, PERIOD);
            prev = last_acc_cyc;
        end
        word_valid = 1'b0;
        wait_commits(c0 + 256);
        for (int i = 0; i < 256; i++) begin
            chk("sram_read", mem.exists(i) ? {24'd0, mem[i]} : 32'h100, i);
        end

        // Random valid, word inputs churning every cycle.
        repeat (400) begin
            @(posedge cclk);
            #1;
            word_valid = 1'($urandom_range(0, 1));
            word_addr  = 8'($urandom);
            word_data  = 8'($urandom);
        end
        word_valid = 1'b0;
        repeat (PERIOD + 4) @(posedge cclk);
        #1;
        chk("random_accounting", commits, accepts - dropped);

        // Reset during bit 7 of a word; it must never commit.
        mem.delete(8'h12);
        c0 = commits;
        send(8'h12, 8'h34);
        word_valid = 1'b0;
        repeat (7) @(posedge cclk);
        #1;
        rst = 1'b1;
        @(negedge cclk);
        chk("midrst_bit7_shifting", shift_enable, 1'b1);
        @(posedge cclk);
        #1;
        rst = 1'b0;
        @(negedge cclk);
        chk("midrst_shift_enable", shift_enable, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", word_ready, 1'b1);
        repeat (PERIOD + 2) @(posedge cclk);
        #1;
        chk("midrst_no_commit", commits, c0);
        chk("midrst_sram_untouched", mem.exists(8'h12) ? 32'd1 : 32'd0, 32'd0);
        send(8'h12, 8'h34);
        word_valid = 1'b0;
        wait_commits(c0 + 1);
        chk("resend_sram", mem.exists(8'h12) ? {24'd0, mem[8'h12]} : 32'h100, 8'h34);

        // CRC checks from a clean reset.
        pulse_rst();
        c0 = commits;
        for (int i = 0; i < 4; i++) send(8'h00, 8'h00);
        word_valid = 1'b0;
        wait_commits(c0 + 4);
        chk("crc_zero_words", crc_out, 8'h00);
        pulse_rst();
        c0 = commits;
        send(8'hA5, 8'h3C);
        word_valid = 1'b0;
        wait_commits(c0 + 1);
`ifdef CONFIG_TX_CRC_EN
        exp_crc = crc_ref(16'hA53C);
`else
        exp_crc = 8'h00;
`endif
        chk("crc_a5_3c", crc_out, exp_crc);

        chk("total_accounting", commits, accepts - dropped);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
